// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : 2^ADDR_W x WIDTH register file, two async reads, one sync write,
//            x0 hardwired to zero. Define WRITE_BYPASS_EN to forward wd3 to
//            any read port that addresses the register being written.
// Revision : 1.0
// ============================================================================
module regfile #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              rst_n
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic              w_wr_en;
    logic [WIDTH-1:0]  w_regs [0:c_DEPTH-1];

    assign w_wr_en   = we3 && (wa3 != '0);
    assign w_regs[0] = '0;

    // Entry 0 has no storage; each remaining entry is its own register.
    generate
        for (genvar gi = 1; gi < c_DEPTH; gi++) begin : g_reg
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_wr_en && (wa3 == ADDR_W'(gi))) begin
                    r_q <= wd3;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

`ifdef WRITE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // Stored value is already zero in reset, so only the forward needs gating.
    assign w_byp1 = rst_n && w_wr_en && (ra1 == wa3);
    assign w_byp2 = rst_n && w_wr_en && (ra2 == wa3);

    assign rd1 = w_byp1 ? wd3 : w_regs[ra1];
    assign rd2 = w_byp2 ? wd3 : w_regs[ra2];
`else
    assign rd1 = w_regs[ra1];
    assign rd2 = w_regs[ra2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Directed, table-driven self-checking bench for regfile.
// Revision : 1.0
// ============================================================================
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [10];

    regfile #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        we3   = 1'b0;
        ra1   = '0;
        ra2   = '0;
        wa3   = '0;
        wd3   = '0;

        vecs[0] = '{1'b1, 5'd1,  32'h00000011, 5'd0,  5'd1,  32'h00000000, 32'h00000011};
        vecs[1] = '{1'b1, 5'd2,  32'h22222222, 5'd1,  5'd2,  32'h00000011, 32'h22222222};
        vecs[2] = '{1'b1, 5'd3,  32'h12345678, 5'd2,  5'd3,  32'h22222222, 32'h12345678};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h00000000, 32'h12345678};
        vecs[4] = '{1'b0, 5'd3,  32'hAAAAAAAA, 5'd3,  5'd0,  32'h12345678, 32'h00000000};
        vecs[5] = '{1'b1, 5'd4,  32'hCAFEBABE, 5'd4,  5'd4,  32'hCAFEBABE, 32'hCAFEBABE};
        vecs[6] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd1,  32'h80000001, 32'h00000011};
        vecs[7] = '{1'b1, 5'd7,  32'h00000001, 5'd7,  5'd2,  32'h00000001, 32'h22222222};
        vecs[8] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd31, 32'hDEADBEEF, 32'h80000001};
        vecs[9] = '{1'b1, 5'd1,  32'h00000055, 5'd1,  5'd3,  32'h00000055, 32'h12345678};

        // Reset state: every address reads zero on both ports.
        repeat (2) @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            chk("reset_rd1", rd1, 32'h0);
            chk("reset_rd2", rd2, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven writes/reads, checked just after the committing edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we3 = vecs[i].we;
            wa3 = vecs[i].wa;
            wd3 = vecs[i].wd;
            ra1 = vecs[i].a1;
            ra2 = vecs[i].a2;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
        end

        // Read-during-write on x7 (holds 0x1).
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd7;
        wd3 = 32'h0BADF00D;
        ra1 = 5'd4;
        ra2 = 5'd7;
        #1;
`ifdef WRITE_BYPASS_EN
        chk("rdw_pre_rd2", rd2, 32'h0BADF00D);
`else
        chk("rdw_pre_rd2", rd2, 32'h00000001);
`endif
        chk("rdw_pre_rd1", rd1, 32'hCAFEBABE);
        @(posedge clk);
        #1;
        chk("rdw_post_rd2", rd2, 32'h0BADF00D);

        // x0 write attempt must not forward or store.
        @(negedge clk);
        we3 = 1'b1;
        wa3 = 5'd0;
        wd3 = 32'hFFFFFFFF;
        ra1 = 5'd0;
        ra2 = 5'd0;
        #1;
        chk("x0_pre_rd1", rd1, 32'h0);
        @(posedge clk);
        #1;
        chk("x0_post_rd2", rd2, 32'h0);

        // Asynchronous reset mid-cycle.
        @(negedge clk);
        we3 = 1'b0;
        ra1 = 5'd5;
        ra2 = 5'd4;
        #1;
        chk("prerst_rd1", rd1, 32'hDEADBEEF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("asyncrst_rd1", rd1, 32'h0);
        chk("asyncrst_rd2", rd2, 32'h0);
        we3 = 1'b1;
        wa3 = 5'd6;
        wd3 = 32'h00000066;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            #1;
            chk("inrst_rd1", rd1, 32'h0);
        end

        // First write after release lands on the first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        we3 = 1'b1;
        wa3 = 5'd6;
        wd3 = 32'h00000066;
        ra1 = 5'd6;
        ra2 = 5'd5;
        @(posedge clk);
        #1;
        chk("postrst_rd1", rd1, 32'h00000066);
        chk("postrst_rd2", rd2, 32'h0);
        @(negedge clk);
        we3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
